reg_wb_scheduler: RTL

- Write-back scheduler and scoreboard in front of the 32x32 register file's single write port.
- Arbitrates between the in-order pipeline write-back (source A) and the long-latency unit write-back (MUL/DIV/load, source B).
- Drives the register-file write port from registers.
- Tracks registers with outstanding long-latency writes and stalls issue on RAW/WAW hazards against them.

---
 rtl/reg_wb_scheduler_if.sv | 66 ++++++
 rtl/reg_wb_scheduler.sv | 134 +++++++++++++
 2 files changed

// File: rtl/reg_wb_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module   : reg_wb_scheduler_if
//  Purpose  : Bundles the issue-stage query, the two write-back request
//             channels and the register-file write port of the write-back
//             scheduler.
//  Ports    : ISS_*  issue-stage hazard query (stall returned)
//             WBA_*  in-order pipeline write-back channel (valid/ready)
//             WBB_*  long-latency unit write-back channel (valid/ready)
//             REG_*  registered register-file write port
//             SB_err sticky scoreboard error flag
//  Modports : slave  = scheduler view, master = requester/testbench view
//  Revision : 1.0 - initial release
// ============================================================================
interface reg_wb_scheduler_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          ISS_valid;
    logic [AW-1:0] ISS_rs;
    logic [AW-1:0] ISS_rt;
    logic          ISS_use_rs;
    logic          ISS_use_rt;
    logic          ISS_wr;
    logic          ISS_long;
    logic [AW-1:0] ISS_rd;
    logic          ISS_stall;

    logic          WBA_valid;
    logic [AW-1:0] WBA_addr;
    logic [DW-1:0] WBA_data;
    logic          WBA_ready;

    logic          WBB_valid;
    logic [AW-1:0] WBB_addr;
    logic [DW-1:0] WBB_data;
    logic          WBB_ready;

    logic          REG_write_1;
    logic [AW-1:0] REG_address_wr;
    logic [DW-1:0] REG_data_wb_in1;
    logic          SB_err;

    modport slave (
        input  ISS_valid, ISS_rs, ISS_rt, ISS_use_rs, ISS_use_rt,
        input  ISS_wr, ISS_long, ISS_rd,
        output ISS_stall,
        input  WBA_valid, WBA_addr, WBA_data,
        output WBA_ready,
        input  WBB_valid, WBB_addr, WBB_data,
        output WBB_ready,
        output REG_write_1, REG_address_wr, REG_data_wb_in1, SB_err
    );

    modport master (
        output ISS_valid, ISS_rs, ISS_rt, ISS_use_rs, ISS_use_rt,
        output ISS_wr, ISS_long, ISS_rd,
        input  ISS_stall,
        output WBA_valid, WBA_addr, WBA_data,
        input  WBA_ready,
        output WBB_valid, WBB_addr, WBB_data,
        input  WBB_ready,
        input  REG_write_1, REG_address_wr, REG_data_wb_in1, SB_err
    );
endinterface
`default_nettype wire

// File: rtl/reg_wb_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : reg_wb_scheduler
//  Purpose  : Write-back scheduler and scoreboard in front of the register
//             file's single write port. Arbitrates pipeline (A) against
//             long-latency (B) write-backs with a starvation guard for B,
//             registers the write port, and tracks registers awaiting a
//             long-latency result to stall RAW/WAW hazards at issue.
//  Ports    : clk        clock, all state on rising edge
//             SYS_reset  synchronous active-high reset
//             bus        reg_wb_scheduler_if.slave (issue, WBA, WBB, REG, SB)
//  Revision : 1.0 - initial release
// ============================================================================
module reg_wb_scheduler #(
    parameter int AW         = 5,
    parameter int DW         = 32,
    parameter int MAX_OUT    = 4,
    parameter int STARVE_MAX = 3
) (
    input  wire logic           clk,
    input  wire logic           SYS_reset,
    reg_wb_scheduler_if.slave   bus
);
    localparam int NREG = 1 << AW;
    localparam int CW   = $clog2(MAX_OUT + 1);
    localparam int SW   = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] C_MAX_OUT    = CW'(MAX_OUT);
    localparam logic [SW-1:0] C_STARVE_MAX = SW'(STARVE_MAX);

    logic [NREG-1:0] r_pending;
    logic [CW-1:0]   r_out_cnt;
    logic [SW-1:0]   r_starve_cnt;
    logic            r_reg_write;
    logic [AW-1:0]   r_reg_addr;
    logic [DW-1:0]   r_reg_data;
    logic            r_sb_err;

    logic            w_force;
    logic            w_a_ready;
    logic            w_b_ready;
    logic            w_a_xfer;
    logic            w_b_xfer;
    logic            w_stall;
    logic            w_iss_set;
    logic            w_b_hit;
    logic            w_b_clr;
    logic            w_b_err;
    logic [NREG-1:0] w_set_mask;
    logic [NREG-1:0] w_clr_mask;
    logic [NREG-1:0] w_pending_nxt;
    logic [AW-1:0]   w_wb_addr;
    logic [DW-1:0]   w_wb_data;

    // B is forced through once it has lost STARVE_MAX consecutive times;
    // at most one of the two channels can transfer in any cycle.
    assign w_force   = bus.WBB_valid & (r_starve_cnt == C_STARVE_MAX);
    assign w_a_ready = ~w_force;
    assign w_b_ready = ~bus.WBA_valid | w_force;
    assign w_a_xfer  = bus.WBA_valid & w_a_ready;
    assign w_b_xfer  = bus.WBB_valid & w_b_ready;

    // Hazard check uses registered scoreboard state only, so a clear landing
    // this cycle releases the stall one cycle later.
    assign w_stall = bus.ISS_valid &
                     ((bus.ISS_use_rs & r_pending[bus.ISS_rs]) |
                      (bus.ISS_use_rt & r_pending[bus.ISS_rt]) |
                      (bus.ISS_wr     & r_pending[bus.ISS_rd]) |
                      (bus.ISS_long & bus.ISS_wr & (r_out_cnt == C_MAX_OUT)));

    // Register 0 is never tracked, so it can never cause a stall.
    assign w_iss_set = bus.ISS_valid & ~w_stall & bus.ISS_wr & bus.ISS_long &
                       (bus.ISS_rd != '0);
    assign w_b_hit   = r_pending[bus.WBB_addr];
    assign w_b_clr   = w_b_xfer & w_b_hit;
    assign w_b_err   = w_b_xfer & ~w_b_hit;

    assign w_set_mask    = w_iss_set ? (NREG'(1) << bus.ISS_rd)   : '0;
    assign w_clr_mask    = w_b_clr   ? (NREG'(1) << bus.WBB_addr) : '0;
    assign w_pending_nxt = (r_pending & ~w_clr_mask) | w_set_mask;

    assign w_wb_addr = w_b_xfer ? bus.WBB_addr : bus.WBA_addr;
    assign w_wb_data = w_b_xfer ? bus.WBB_data : bus.WBA_data;

    always_ff @(posedge clk) begin
        if (SYS_reset) begin
            r_pending    <= '0;
            r_out_cnt    <= '0;
            r_starve_cnt <= '0;
            r_reg_write  <= 1'b0;
            r_reg_addr   <= '0;
            r_reg_data   <= '0;
            r_sb_err     <= 1'b0;
        end else begin
            r_pending <= w_pending_nxt;

            // Simultaneous set and clear cancel out.
            if (w_iss_set && !w_b_clr) begin
                r_out_cnt <= r_out_cnt + 1'b1;
            end else if (w_b_clr && !w_iss_set) begin
                r_out_cnt <= r_out_cnt - 1'b1;
            end

            if (!bus.WBB_valid || w_b_xfer) begin
                r_starve_cnt <= '0;
            end else if (r_starve_cnt != C_STARVE_MAX) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end

            // Address/data hold between transfers; a write to r0 is accepted
            // but never asserts the enable.
            if (w_a_xfer || w_b_xfer) begin
                r_reg_write <= (w_wb_addr != '0);
                r_reg_addr  <= w_wb_addr;
                r_reg_data  <= w_wb_data;
            end else begin
                r_reg_write <= 1'b0;
            end

            if (w_b_err) begin
                r_sb_err <= 1'b1;
            end
        end
    end

    assign bus.ISS_stall       = w_stall;
    assign bus.WBA_ready       = w_a_ready;
    assign bus.WBB_ready       = w_b_ready;
    assign bus.REG_write_1     = r_reg_write;
    assign bus.REG_address_wr  = r_reg_addr;
    assign bus.REG_data_wb_in1 = r_reg_data;
    assign bus.SB_err          = r_sb_err;

endmodule
`default_nettype wire
